// File: rtl/io_output_pkg.sv
// Shared constants, index-width helper and write-FIFO entry type for the I/O output bank.
// Readback ports are enabled elsewhere by defining IO_OUTPUT_READBACK_EN.
package io_output_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_NUM_CHANNELS = 4;
  localparam logic [9:0] DEF_BASE_ADDR = 10'h3F0;
  localparam int DEF_FIFO_DEPTH = 4;

  // A single-channel bank still needs a 1-bit index field to form a legal struct.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CH_IDX_W = ch_idx_w(DEF_NUM_CHANNELS);

  typedef struct packed {
    logic [CH_IDX_W-1:0]       idx;
    logic [DEF_DATA_WIDTH-1:0] data;
  } io_wr_entry_t;

endpackage

// File: rtl/io_output_bank_if.sv
// Processor store bus plus per-channel valid/ack handshake for io_output_bank.
// With IO_OUTPUT_READBACK_EN defined, rd_data and pending are added.
interface io_output_bank_if
  import io_output_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
);

  logic [DATA_WIDTH-1:0]              dataC;
  logic [ADDR_WIDTH-1:0]              address;
  logic                               IO_RAMwrite;
  logic                               stall;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] ch_data;
  logic [NUM_CHANNELS-1:0]            ch_valid;
  logic [NUM_CHANNELS-1:0]            ch_ack;

`ifdef IO_OUTPUT_READBACK_EN
  logic [DATA_WIDTH-1:0]              rd_data;
  logic [$clog2(FIFO_DEPTH):0]        pending;

  modport master (
    output dataC, address, IO_RAMwrite, ch_ack,
    input  stall, ch_data, ch_valid, rd_data, pending
  );

  modport slave (
    input  dataC, address, IO_RAMwrite, ch_ack,
    output stall, ch_data, ch_valid, rd_data, pending
  );
`else
  modport master (
    output dataC, address, IO_RAMwrite, ch_ack,
    input  stall, ch_data, ch_valid
  );

  modport slave (
    input  dataC, address, IO_RAMwrite, ch_ack,
    output stall, ch_data, ch_valid
  );
`endif

endinterface

// File: rtl/io_write_fifo.sv
// In-order pending-write FIFO; DEPTH must be a power of two so pointers wrap naturally.
module io_write_fifo
  import io_output_pkg::*;
#(
  parameter type entry_t = io_wr_entry_t,
  parameter int  DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   push,
  input  entry_t                 push_data,
  input  logic                   pop,
  output entry_t                 pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   cnt;
  logic             do_push;
  logic             do_pop;

  assign full     = (cnt == (PTR_W + 1)'(DEPTH));
  assign empty    = (cnt == '0);
  assign count    = cnt;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: an entry is only ever read after it has been written.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/io_output_bank.sv
// Memory-mapped multi-channel output bank: decoded stores queue in order, then land in channel registers.
// Define IO_OUTPUT_READBACK_EN to add the rd_data readback mux and the pending entry count.
module io_output_bank
  import io_output_pkg::*;
#(
  parameter int                    DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int                    ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int                    NUM_CHANNELS = DEF_NUM_CHANNELS,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = DEF_BASE_ADDR,
  parameter int                    FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input logic             clock,
  input logic             reset_n,
  io_output_bank_if.slave bus
);

  localparam int CH_W  = ch_idx_w(NUM_CHANNELS);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [CH_W-1:0]       idx;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  logic [ADDR_WIDTH-1:0]              addr_off;
  logic [CH_W-1:0]                    addr_idx;
  logic                               in_range;
  entry_t                             push_entry;
  entry_t                             head;
  logic                               fifo_push;
  logic                               fifo_pop;
  logic                               fifo_full;
  logic                               fifo_empty;
  logic [CNT_W-1:0]                   fifo_count;
  logic                               head_free;
  logic [DATA_WIDTH-1:0]              ch_reg [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]            ch_valid_q;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] ch_data_flat;

  // Offset compare avoids overflow when the window sits at the top of the address space.
  assign addr_off = bus.address - BASE_ADDR;
  assign in_range = (bus.address >= BASE_ADDR) && (addr_off < ADDR_WIDTH'(NUM_CHANNELS));
  assign addr_idx = addr_off[CH_W-1:0];

  assign push_entry.idx  = addr_idx;
  assign push_entry.data = bus.dataC;
  assign fifo_push       = bus.IO_RAMwrite && in_range && !fifo_full;

  io_write_fifo #(
    .entry_t (entry_t),
    .DEPTH   (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // A channel accepts the head when idle or when its consumer acks this very cycle.
  assign head_free = !ch_valid_q[head.idx] || bus.ch_ack[head.idx];
  assign fifo_pop  = !fifo_empty && head_free;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CHANNELS; i++) ch_reg[i] <= '0;
      ch_valid_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (fifo_pop && (head.idx == CH_W'(i))) begin
          ch_reg[i]     <= head.data;
          ch_valid_q[i] <= 1'b1;
        end else if (bus.ch_ack[i]) begin
          ch_valid_q[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    ch_data_flat = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      ch_data_flat[i*DATA_WIDTH +: DATA_WIDTH] = ch_reg[i];
    end
  end

  assign bus.ch_data  = ch_data_flat;
  assign bus.ch_valid = ch_valid_q;
  assign bus.stall    = (fifo_count == CNT_W'(FIFO_DEPTH));

`ifdef IO_OUTPUT_READBACK_EN
  assign bus.rd_data = in_range ? ch_reg[addr_idx] : '0;
  assign bus.pending = fifo_count;
`endif

endmodule

// File: doc/io_output_bank.md
# io_output_bank

Parametrised, clocked output-port bank for the processor's memory-mapped I/O space. It generalises the single latched output register to NUM_CHANNELS independent output channels. Each channel has a valid/ack handshake toward its external consumer, such as a display driver or LED bank. Processor stores to the channel address window pass through an in-order write FIFO, and the block raises a stall when that FIFO cannot accept a store.

## Interface
Parameters:
- DATA_WIDTH, 32, width of stored data and of each channel register
- ADDR_WIDTH, 10, width of the processor data address
- NUM_CHANNELS, 4, number of output channels (1..16)
- BASE_ADDR, 10'h3F0, address of channel 0; channel i is at BASE_ADDR+i
- FIFO_DEPTH, 4, pending-write FIFO entries (power of two, ≥2)

Ports:
- clock  in  1  single clock; all state updates on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- dataC  in  DATA_WIDTH  store data from the datapath
- address  in  ADDR_WIDTH  store address
- IO_RAMwrite  in  1  store strobe, one cycle per store
- stall  out  1  FIFO full; the processor must hold the store and retry
- ch_data  out  NUM_CHANNELS*DATA_WIDTH  channel registers, packed; channel i is bits [i*DATA_WIDTH +: DATA_WIDTH]
- ch_valid  out  NUM_CHANNELS  channel holds a value not yet acknowledged
- ch_ack  in  NUM_CHANNELS  consumer acknowledge, sampled only while the matching ch_valid is 1

## Operation
- A store is in range when BASE_ADDR ≤ address < BASE_ADDR+NUM_CHANNELS. Channel index = address − BASE_ADDR, truncated to $clog2(NUM_CHANNELS) bits.
- Push: when IO_RAMwrite=1, the store is in range, and stall=0, the pair {index, dataC} is enqueued.
- Out-of-range stores are ignored. They never assert stall.
- A store presented while stall=1 is dropped. This holds even if a pop occurs in the same cycle. The processor holds its store until stall=0.
- Pop: the head entry is popped when the FIFO is non-empty and its target channel is free. A channel is free when ch_valid[i]=0, or when ch_valid[i]=1 and ch_ack[i]=1 in the same cycle.
- On pop: ch_data[i] ← head data and ch_valid[i] ← 1.
- Order is strictly in-order. A head waiting on a busy channel blocks every later entry, including entries for free channels (head-of-line blocking).
- Ack: ch_ack[i]=1 while ch_valid[i]=1 clears ch_valid[i], unless a pop to channel i happens in the same cycle; then ch_valid[i] stays 1 and ch_data[i] takes the new value.
- ch_ack[i] while ch_valid[i]=0 is ignored.
- ch_data[i] keeps its last value after ack. It changes only on a pop to channel i.
- Simultaneous push and pop in a non-full FIFO: both occur, and the entry count is unchanged.
- Pointers wrap modulo FIFO_DEPTH. An extra count bit distinguishes full from empty.
- stall = (count == FIFO_DEPTH). stall is combinational from registered state only, never from inputs.

## Timing
- Reset (asynchronous assert, synchronous deassert handled upstream):
  - FIFO empty, pointers 0
  - ch_data all 0, ch_valid all 0
  - stall 0
- An assertion mid-operation discards every pending entry and clears all channels. No partial delivery survives.
- Latency: store at edge k sets ch_valid[i] after edge k+1, provided the channel is free and the FIFO was empty. There is no push-to-output bypass.
- Throughput: one pop per cycle. When all targets are free, back-to-back stores to different channels drain at 1/cycle.
- stall rises the cycle after the push that fills the FIFO. It falls the cycle after the first pop from full.

## Configuration
- IO_OUTPUT_READBACK_EN defined:
  - adds output rd_data [DATA_WIDTH] = ch_data[address − BASE_ADDR] when address is in range, else 0 (combinational)
  - adds output pending [$clog2(FIFO_DEPTH)+1] = FIFO entry count
- Undefined: neither port exists. Write-only behaviour is otherwise identical.

## Structure
- Package io_output_pkg holds:
  - default parameter constants
  - CH_IDX_W = $clog2(NUM_CHANNELS) helper
  - typedef io_wr_entry_t {channel index, data}
- Sub-module io_write_fifo: synchronous FIFO of io_wr_entry_t with push/pop/full/empty/count. It is instantiated once.
- Address decode, the per-channel handshake registers and the readback mux live in the top level.

## Test plan
- Reset then idle → all ch_valid=0, ch_data=0, stall=0. Assert reset_n=0 mid-drain → FIFO empties and ch_valid clears immediately.
- Store 32'hDEAD_BEEF to BASE_ADDR+2, ch_ack=0 → ch_valid[2]=1 two edges later, data correct. Pulse ch_ack[2] → ch_valid[2]=0, ch_data[2] holds DEAD_BEEF.
- Store to 10'h000 and to BASE_ADDR+NUM_CHANNELS → no enqueue, no channel change, stall stays 0.
- Hold ch_ack=0 and store ch1 twice, then ch0 ×3 → ch0 stays blocked behind the second ch1 entry. After 4 pending entries stall=1 and a 5th store is dropped. Ack ch1 → drain in order.
- With ch_valid[3]=1, pop a new ch3 entry in the same cycle as ch_ack[3] → ch_valid[3] remains 1 with the new data.
- IO_OUTPUT_READBACK_EN defined: rd_data tracks ch_data[1] at BASE_ADDR+1, and pending counts 0→3→0 across a burst.
